// File: rtl/mm_copy_engine_if.sv
// Avalon-MM read/write master pair (control + user buffer ports) seen by mm_copy_engine.
// master: the copy engine side; slave: the PCIe read/write master pair side.
interface mm_copy_engine_if #(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32
) ();
  logic                    read_control_fixed_location;
  logic [ADDRESSWIDTH-1:0] read_control_read_base;
  logic [ADDRESSWIDTH-1:0] read_control_read_length;
  logic                    read_control_go;
  logic                    read_control_done;
  logic                    read_user_read_buffer;
  logic [DATAWIDTH-1:0]    read_user_buffer_output_data;
  logic                    read_user_data_available;

  logic                    write_control_fixed_location;
  logic [ADDRESSWIDTH-1:0] write_control_write_base;
  logic [ADDRESSWIDTH-1:0] write_control_write_length;
  logic                    write_control_go;
  logic                    write_control_done;
  logic                    write_user_write_buffer;
  logic [DATAWIDTH-1:0]    write_user_buffer_data;
  logic                    write_user_buffer_full;

  modport master (
    output read_control_fixed_location, read_control_read_base, read_control_read_length,
    output read_control_go, read_user_read_buffer,
    input  read_control_done, read_user_buffer_output_data, read_user_data_available,
    output write_control_fixed_location, write_control_write_base, write_control_write_length,
    output write_control_go, write_user_write_buffer, write_user_buffer_data,
    input  write_control_done, write_user_buffer_full
  );

  modport slave (
    input  read_control_fixed_location, read_control_read_base, read_control_read_length,
    input  read_control_go, read_user_read_buffer,
    output read_control_done, read_user_buffer_output_data, read_user_data_available,
    input  write_control_fixed_location, write_control_write_base, write_control_write_length,
    input  write_control_go, write_user_write_buffer, write_user_buffer_data,
    output write_control_done, write_user_buffer_full
  );
endinterface

// File: rtl/mm_copy_engine.sv
// Host-memory copy engine: read master -> show-ahead FIFO -> write master, one start/done per copy.
// Optional MM_COPY_ENGINE_CHKSUM_EN adds a `checksum` port (XOR of every word written).
module mm_copy_engine #(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESSWIDTH-1:0] src_base,
  input  logic [ADDRESSWIDTH-1:0] dst_base,
  input  logic [ADDRESSWIDTH-1:0] word_count,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             status,
`ifdef MM_COPY_ENGINE_CHKSUM_EN
  output logic [DATAWIDTH-1:0]    checksum,
`endif
  mm_copy_engine_if.master        mm
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GO     = 2'd1;
  localparam logic [1:0] XFER   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam int                      PTR_W          = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]          PTR_ONE        = 1;
  localparam logic [ADDRESSWIDTH-1:0] CNT_ONE        = 1;
  localparam logic [ADDRESSWIDTH-1:0] BYTES_PER_WORD = ADDRESSWIDTH'(DATAWIDTH / 8);

  logic [1:0]              state_q, state_d;
  logic [ADDRESSWIDTH-1:0] src_q, dst_q, count_q;
  logic [ADDRESSWIDTH-1:0] rd_cnt_q, wr_cnt_q;
  logic [PTR_W:0]          wr_ptr_q, rd_ptr_q;
  logic                    first_q, wdone_q;
  logic [DATAWIDTH-1:0]    mem [FIFO_DEPTH];

  logic                    accept, in_xfer, fifo_empty, fifo_full, push, drain;
  logic [DATAWIDTH-1:0]    head;

  assign accept     = (state_q == IDLE) && start;
  assign in_xfer    = (state_q == XFER);
  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push       = in_xfer && mm.read_user_data_available && !fifo_full && (rd_cnt_q < count_q);
  assign drain      = in_xfer && !fifo_empty && !mm.write_user_buffer_full;
  assign head       = mem[rd_ptr_q[PTR_W-1:0]];

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (word_count == '0) ? FINISH : GO;
      GO:      state_d = XFER;
      XFER:    if ((wr_cnt_q == count_q) && wdone_q) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      count_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      first_q  <= 1'b0;
      wdone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= (state_q == GO);
      if (accept) begin
        src_q    <= src_base;
        dst_q    <= dst_base;
        count_q  <= word_count;
        rd_cnt_q <= '0;
        wr_cnt_q <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        wdone_q  <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
          rd_cnt_q <= rd_cnt_q + CNT_ONE;
        end
        if (drain) begin
          rd_ptr_q <= rd_ptr_q + PTR_ONE;
          wr_cnt_q <= wr_cnt_q + CNT_ONE;
        end
        // Completion from the write master is trusted only after the first XFER cycle.
        if (in_xfer && !first_q && mm.write_control_done) wdone_q <= 1'b1;
      end
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[PTR_W-1:0]] <= mm.read_user_buffer_output_data;
  end

`ifdef MM_COPY_ENGINE_CHKSUM_EN
  logic [DATAWIDTH-1:0] chk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      chk_q <= '0;
    else if (accept) chk_q <= '0;
    else if (drain)  chk_q <= chk_q ^ head;
  end

  assign checksum = chk_q;
`endif

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FINISH);
  assign status = {2'b00, state_q, rd_cnt_q[11:0], wr_cnt_q[15:0]};

  assign mm.read_control_fixed_location  = 1'b0;
  assign mm.write_control_fixed_location = 1'b0;
  assign mm.read_control_read_base       = src_q;
  assign mm.write_control_write_base     = dst_q;
  assign mm.read_control_read_length     = count_q * BYTES_PER_WORD;
  assign mm.write_control_write_length   = count_q * BYTES_PER_WORD;
  assign mm.read_control_go              = (state_q == GO);
  assign mm.write_control_go             = (state_q == GO);
  assign mm.read_user_read_buffer        = push;
  assign mm.write_user_write_buffer      = drain;
  assign mm.write_user_buffer_data       = fifo_empty ? '0 : head;

endmodule

// File: tb/tb_mm_copy_engine.sv
// Scoreboard bench for mm_copy_engine: directed copies push expected write data into a queue,
// a monitor pops and compares every word the write master accepts.
module tb_mm_copy_engine;
  localparam int AW = 28;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_base = '0, dst_base = '0, word_count = '0;
  logic          busy, done;
  logic [31:0]   status;
`ifdef MM_COPY_ENGINE_CHKSUM_EN
  logic [DW-1:0] checksum;
`endif

  mm_copy_engine_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) mm ();

  mm_copy_engine #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_base(src_base), .dst_base(dst_base), .word_count(word_count),
    .busy(busy), .done(done), .status(status),
`ifdef MM_COPY_ENGINE_CHKSUM_EN
    .checksum(checksum),
`endif
    .mm(mm)
  );

  always #5 clk = ~clk;

  int check_total = 0;
  int check_pass  = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_total++;
    if (act === exp) check_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Slave-side models of the read and write masters.
  logic [DW-1:0] src_mem [64];
  int            src_len = 0;
  int            src_idx = 0;
  int            wr_seen = 0;
  int            wr_target = 0;
  logic          model_clr = 1'b0;
  logic          wfull = 1'b0;

  assign mm.read_user_data_available     = (src_idx < src_len);
  assign mm.read_user_buffer_output_data = (src_idx < 64) ? src_mem[src_idx] : '0;
  assign mm.read_control_done            = (src_len != 0) && (src_idx == src_len);
  assign mm.write_control_done           = (wr_target != 0) && (wr_seen == wr_target);
  assign mm.write_user_buffer_full       = wfull;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_idx <= 0;
      wr_seen <= 0;
    end else if (model_clr) begin
      src_idx <= 0;
      wr_seen <= 0;
    end else begin
      if (mm.read_user_read_buffer)   src_idx <= src_idx + 1;
      if (mm.write_user_write_buffer) wr_seen <= wr_seen + 1;
    end
  end

  int cyc = 0, start_cyc = 0, done_cyc = 0, go_cnt = 0, done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted write is compared against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      if (mm.read_control_go) go_cnt++;
      if (done) done_cnt++;
      if (mm.write_user_write_buffer) begin
        if (exp_q.size() == 0) begin
          check_total++;
          $display("FAIL wdata_extra: got %0h expected no write", mm.write_user_buffer_data);
        end else begin
          check("wdata", mm.write_user_buffer_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic load(input int n, input logic [DW-1:0] base_word);
    for (int i = 0; i < n; i++) begin
      src_mem[i] = base_word + DW'(i);
      exp_q.push_back(base_word + DW'(i));
    end
    src_len = n;
  endtask

  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW-1:0] n, input bit accept);
    @(negedge clk);
    src_base = s; dst_base = d; word_count = n; start = 1'b1;
    if (accept) begin
      model_clr = 1'b1;
      wr_target = int'(n);
      start_cyc = cyc;
    end
    @(negedge clk);
    start = 1'b0;
    model_clr = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!seen) begin
      check_total++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  int go_before, done_before;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_status", status, 32'h0);
    check("rst_ctrl", {mm.read_control_go, mm.write_control_go, mm.read_user_read_buffer,
                       mm.write_user_write_buffer, mm.read_control_fixed_location,
                       mm.write_control_fixed_location}, 6'b0);
    check("rst_bases", {mm.read_control_read_base, mm.write_control_write_base}, 56'h0);
    reset = 1'b1;
    @(negedge clk);

    // Basic copy: 8 words 1..8, 0x100 -> 0x800
    load(8, 32'h1);
    do_start(28'h100, 28'h800, 28'd8, 1'b1);
    check("basic_go", {mm.read_control_go, mm.write_control_go, busy}, 3'b111);
    check("basic_rbase", mm.read_control_read_base, 28'h100);
    check("basic_wbase", mm.write_control_write_base, 28'h800);
    check("basic_lens", {mm.read_control_read_length, mm.write_control_write_length},
          {28'd32, 28'd32});
    check("basic_status_go", status, 32'h1000_0000);
    @(negedge clk);
    check("basic_status_xfer", status[31:28], 4'h2);
    wait_done(100);
    check("basic_done_latency", done_cyc - start_cyc, 13);
    check("basic_status_fin", status, 32'h3008_0008);
    @(negedge clk);
    check("basic_idle", {busy, done}, 2'b00);
    check("basic_drained", exp_q.size(), 0);

    // Backpressure: write side full for 40 cycles, 32 words through a 16-deep FIFO
    wfull = 1'b1;
    load(32, 32'h1000);
    do_start(28'h2000, 28'h4000, 28'd32, 1'b1);
    repeat (39) @(negedge clk);
    check("bp_pops", src_idx, 16);
    check("bp_rd_held", mm.read_user_read_buffer, 1'b0);
    check("bp_status", status, 32'h2010_0000);
    wfull = 1'b0;
    wait_done(200);
    check("bp_status_fin", status, 32'h3020_0020);
    check("bp_drained", exp_q.size(), 0);

    // Zero count: done next cycle, no go pulses
    go_before = go_cnt;
    do_start(28'h40, 28'h80, 28'd0, 1'b1);
    check("zero_done_busy_go", {done, busy, mm.read_control_go, mm.write_control_go}, 4'b1100);
    @(negedge clk);
    check("zero_idle", {busy, done}, 2'b00);
    repeat (3) @(negedge clk);
    check("zero_no_go", go_cnt - go_before, 0);

    // Start while busy (mid-XFER and during FINISH) is dropped
    go_before = go_cnt;
    load(6, 32'h11);
    do_start(28'h200, 28'h900, 28'd6, 1'b1);
    repeat (2) @(negedge clk);
    do_start(28'h300, 28'hA00, 28'd2, 1'b0);
    check("busy_rbase", mm.read_control_read_base, 28'h200);
    check("busy_wbase", mm.write_control_write_base, 28'h900);
    check("busy_len", mm.read_control_read_length, 28'd24);
    wait_done(100);
    start = 1'b1;
    src_base = 28'h400;
    @(negedge clk);
    start = 1'b0;
    check("fin_start_busy", busy, 1'b0);
    @(negedge clk);
    check("fin_start_idle", busy, 1'b0);
    check("busy_go_once", go_cnt - go_before, 1);
    check("busy_drained", exp_q.size(), 0);

    // Reset mid-XFER after 5 of 10 words, then a fresh 4-word copy
    load(10, 32'h30);
    do_start(28'h500, 28'hB00, 28'd10, 1'b1);
    begin
      int k = 0;
      while (wr_seen != 5 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    check("rst_mid_reached", wr_seen, 5);
    done_before = done_cnt;
    #1 reset = 1'b0;
    #1;
    check("rstm_busy_done", {busy, done}, 2'b00);
    check("rstm_status", status, 32'h0);
    check("rstm_ctrl", {mm.read_control_go, mm.write_control_go, mm.read_user_read_buffer,
                        mm.write_user_write_buffer}, 4'b0);
    check("rstm_addr", {mm.read_control_read_base, mm.write_control_write_base,
                        mm.read_control_read_length, mm.write_control_write_length}, 112'h0);
    check("rstm_wdata", mm.write_user_buffer_data, 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstm_no_done", done_cnt - done_before, 0);
    load(4, 32'hC1);
    do_start(28'h600, 28'hC00, 28'd4, 1'b1);
    check("fresh_rbase", mm.read_control_read_base, 28'h600);
    wait_done(100);
    check("fresh_status_fin", status, 32'h3004_0004);
    check("fresh_drained", exp_q.size(), 0);

`ifdef MM_COPY_ENGINE_CHKSUM_EN
    src_mem[0] = 32'hA5A5_A5A5;
    src_mem[1] = 32'h0F0F_0F0F;
    exp_q.push_back(32'hA5A5_A5A5);
    exp_q.push_back(32'h0F0F_0F0F);
    src_len = 2;
    do_start(28'h700, 28'hD00, 28'd2, 1'b1);
    wait_done(100);
    @(negedge clk);
    check("chksum", checksum, 32'hAAAA_AAAA);
`endif

    repeat (3) @(negedge clk);
    check("final_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", check_pass, check_total);
    $finish;
  end

endmodule
